reception_dispatcher: RTL and testbench
=======================================

Name: reception_dispatcher

Overview:
- Parametrised multi-doctor patient dispatcher for the automated reception desk.
- Accepts patient requests that name either a specific doctor or "any doctor", and issues a sequential token on acceptance.
- Buffers requests in an in-order queue and dispatches each to a free doctor.
- Each doctor's busy state is held by a consultation countdown timer, which an explicit early-release input can clear.

Parameters:
- N_DOC, 4, number of doctors (2..16).
- CONSULT_CYC, 10, consultation length in clk cycles (>=1).
- QDEPTH, 8, request queue depth (power of 2, >=2).
- TOKW, 8, token counter width.
- DW, $clog2(N_DOC), doctor index width (derived, not overridable).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous active-high reset.
- req_valid  in  1  patient request present.
- req_any  in  1  1 = any free doctor acceptable; 0 = use req_doc.
- req_doc  in  DW  preferred doctor index.
- req_ready  out  1  queue can accept (combinational: ~full & ~rst).
- ack_valid  out  1  one-cycle pulse: request accepted.
- ack_token  out  TOKW  token issued to the accepted request.
- msg_valid  out  1  one-cycle pulse: patient dispatched.
- msg_doc  out  DW  doctor assigned.
- msg_token  out  TOKW  token of the dispatched patient.
- doc_release  in  N_DOC  per-doctor early finish strobe.
- doc_busy  out  N_DOC  registered per-doctor busy flags.
- q_count  out  $clog2(QDEPTH)+1  current queue occupancy.

Behaviour:
- Reset (rst high at a clk edge):
  - queue emptied; q_count=0.
  - token counter=0.
  - all timers=0; doc_busy=0.
  - ack_valid=0, ack_token=0, msg_valid=0, msg_doc=0, msg_token=0.
  - Reset mid-consultation or with a non-empty queue discards all state; no dispatch message is emitted for discarded entries.
- Accept:
  - A request is accepted at edge T when req_valid & req_ready.
  - The entry {any, doc, token} is pushed to the queue.
  - After edge T: ack_valid=1 for one cycle with ack_token=current token, and the token counter increments.
  - Token wraps from 2^TOKW-1 to 0.
- Request normalisation:
  - req_doc >= N_DOC (possible when N_DOC is not a power of 2) is treated as req_any=1.
- Dispatch:
  - Strictly in order. Only the queue head is considered; there is no bypass, so head-of-line blocking is intended.
  - Head is dispatchable if:
    - any=1 and at least one doctor is free, or
    - any=0 and doctor[doc] is free.
  - Any-doctor selection: lowest-index free doctor.
  - On a dispatch edge:
    - the head is popped;
    - the chosen doctor's timer is loaded with CONSULT_CYC;
    - msg_valid=1, msg_doc and msg_token are registered for one cycle.
  - At most one dispatch per cycle.
- Latency:
  - Minimum is accept at edge T, dispatch at edge T+1, with msg_valid visible after T+1.
  - This holds when the queue was empty and the target doctor is free.
- Timers, per doctor:
  - Nonzero timer decrements by 1 each cycle; doc_busy[i] = (timer != 0).
  - A doctor is free for dispatch when its timer is 0.
  - doc_release[i] forces timer[i]=0 at that edge. The doctor becomes eligible for dispatch at the following edge, because dispatch uses pre-edge state.
  - doc_release on an already free doctor has no effect.
  - The timer reaching 0 makes the doctor dispatchable at the next edge.
- Simultaneous push and pop:
  - Allowed when the queue is not full; q_count is unchanged.
  - When full, req_ready=0 even if a pop occurs the same cycle.
  - Empty queue: no dispatch, msg_valid=0.
- Width rules: q_count ranges 0..QDEPTH. Timer width is $clog2(CONSULT_CYC+1).

Test Plan:
- Reset release, queue empty, all doctors free. Request {any=0, doc=2} accepted at edge 1 -> ack_token=0 after edge 1; msg_valid with msg_doc=2, msg_token=0 after edge 2; doc_busy=4'b0100 for 10 cycles, then clears.
- 5 back-to-back {any=1} requests -> tokens 0..4; dispatched on consecutive cycles to doctors 0,1,2,3. Token 4 waits until doctor 0's timer expires, then dispatches to doctor 0.
- Head {doc=1} blocked while doctor 1 busy, next entry {any=1}, doctors 2..3 free -> no dispatch until doctor 1 frees (head-of-line). Assert doc_release[1] -> head dispatches to doctor 1 at the next edge; {any} entry dispatches to doctor 0 or 2 the cycle after.
- Doctor 0 busy, queue full (8 entries, all {doc=0}) -> req_ready=0 and a 9th request is not acked. One dispatch frees a slot -> req_ready=1 next cycle, q_count=7.
- Token wrap with TOKW=3 -> 9 accepted requests yield ack_tokens 0..7 then 0.
- Assert rst with 3 entries queued and 2 doctors busy -> after the reset edge q_count=0, doc_busy=0, no msg_valid. The next request gets token 0.

Source files
------------

// File: rtl/reception_dispatcher.sv
// rtl/reception_dispatcher.sv - in-order patient request queue dispatching to N_DOC doctors
// with per-doctor consultation countdown timers and early release.
module reception_dispatcher #(
   parameter int N_DOC       = 4,
   parameter int CONSULT_CYC = 10,
   parameter int QDEPTH      = 8,
   parameter int TOKW        = 8,
   localparam int DW         = $clog2(N_DOC)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      req_valid,
   input  logic                      req_any,
   input  logic [DW-1:0]             req_doc,
   output logic                      req_ready,
   output logic                      ack_valid,
   output logic [TOKW-1:0]           ack_token,
   output logic                      msg_valid,
   output logic [DW-1:0]             msg_doc,
   output logic [TOKW-1:0]           msg_token,
   input  logic [N_DOC-1:0]          doc_release,
   output logic [N_DOC-1:0]          doc_busy,
   output logic [$clog2(QDEPTH):0]   q_count
);

   localparam int QW = $clog2(QDEPTH);
   localparam int TW = $clog2(CONSULT_CYC + 1);
   localparam logic [DW:0] NDOC_W = (DW + 1)'(N_DOC);

   logic            q_any [QDEPTH];
   logic [DW-1:0]   q_doc [QDEPTH];
   logic [TOKW-1:0] q_tok [QDEPTH];
   logic [QW-1:0]   head, tail;
   logic [QW:0]     count;
   logic [TOKW-1:0] token;
   logic [TW-1:0]   timer [N_DOC];

   logic [N_DOC-1:0] free;
   logic             full, push, pop, req_any_n;
   logic             head_any, any_ok;
   logic [DW-1:0]    head_doc, any_sel, sel_doc;

   assign full      = (count == (QW + 1)'(QDEPTH));
   assign req_ready = ~full & ~rst;
   assign push      = req_valid & req_ready;
   // Out-of-range doctor indices fall back to "any doctor".
   assign req_any_n = req_any | ({1'b0, req_doc} >= NDOC_W);
   assign q_count   = count;
   assign doc_busy  = ~free;

   assign head_any = q_any[head];
   assign head_doc = q_doc[head];

   always_comb begin
      any_sel = '0;
      any_ok  = 1'b0;
      for (int i = N_DOC - 1; i >= 0; i--) begin
         free[i] = (timer[i] == '0);
         if (timer[i] == '0) begin
            any_sel = DW'(i);
            any_ok  = 1'b1;
         end
      end
   end

   // Only the head is eligible: head-of-line blocking is deliberate.
   assign pop     = (count != '0) & (head_any ? any_ok : free[head_doc]);
   assign sel_doc = head_any ? any_sel : head_doc;

   always_ff @(posedge clk) begin
      if (rst) begin
         head      <= '0;
         tail      <= '0;
         count     <= '0;
         token     <= '0;
         ack_valid <= 1'b0;
         ack_token <= '0;
         msg_valid <= 1'b0;
         msg_doc   <= '0;
         msg_token <= '0;
         for (int i = 0; i < N_DOC; i++) timer[i] <= '0;
      end else begin
         ack_valid <= push;
         if (push) begin
            q_any[tail] <= req_any_n;
            q_doc[tail] <= req_doc;
            q_tok[tail] <= token;
            tail        <= tail + 1'b1;
            token       <= token + 1'b1;
            ack_token   <= token;
         end

         msg_valid <= pop;
         if (pop) begin
            head      <= head + 1'b1;
            msg_doc   <= sel_doc;
            msg_token <= q_tok[head];
         end

         count <= count + {{QW{1'b0}}, push} - {{QW{1'b0}}, pop};

         // A dispatch only targets a free doctor, so it never collides with a useful release.
         for (int i = 0; i < N_DOC; i++) begin
            if (pop && sel_doc == DW'(i))
               timer[i] <= TW'(CONSULT_CYC);
            else if (doc_release[i])
               timer[i] <= '0;
            else if (timer[i] != '0)
               timer[i] <= timer[i] - 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_reception_dispatcher.sv
// tb/tb_reception_dispatcher.sv - directed self-checking bench for reception_dispatcher
// (default instance plus a TOKW=3 instance for token wrap).
module tb_reception_dispatcher;

   logic       clk = 1'b0;
   logic       rst;
   logic       req_valid, req_any;
   logic [1:0] req_doc;
   logic [3:0] doc_release;

   logic       req_ready, ack_valid, msg_valid;
   logic [7:0] ack_token, msg_token;
   logic [1:0] msg_doc;
   logic [3:0] doc_busy, q_count;

   logic       w_req_ready, w_ack_valid, w_msg_valid;
   logic [2:0] w_ack_token, w_msg_token;
   logic [1:0] w_msg_doc;
   logic [3:0] w_doc_busy, w_q_count;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   reception_dispatcher dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_any(req_any), .req_doc(req_doc),
      .req_ready(req_ready), .ack_valid(ack_valid), .ack_token(ack_token),
      .msg_valid(msg_valid), .msg_doc(msg_doc), .msg_token(msg_token),
      .doc_release(doc_release), .doc_busy(doc_busy), .q_count(q_count)
   );

   reception_dispatcher #(.TOKW(3)) dut_w (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_any(req_any), .req_doc(req_doc),
      .req_ready(w_req_ready), .ack_valid(w_ack_valid), .ack_token(w_ack_token),
      .msg_valid(w_msg_valid), .msg_doc(w_msg_doc), .msg_token(w_msg_token),
      .doc_release(doc_release), .doc_busy(w_doc_busy), .q_count(w_q_count)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; req_valid = 1'b0; req_any = 1'b0; req_doc = '0; doc_release = '0;
      tick();
      rst = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (q_count !== 4'd0) begin failures++; $display("FAIL reset_q_count got %0d exp 0", q_count); end
      checks++; if (doc_busy !== 4'b0000) begin failures++; $display("FAIL reset_doc_busy got %b exp 0000", doc_busy); end
      checks++; if (ack_valid !== 1'b0 || msg_valid !== 1'b0) begin failures++; $display("FAIL reset_valids got ack=%b msg=%b exp 0 0", ack_valid, msg_valid); end
      checks++; if (ack_token !== 8'd0 || msg_token !== 8'd0 || msg_doc !== 2'd0) begin failures++; $display("FAIL reset_regs got ack_tok=%0d msg_tok=%0d msg_doc=%0d exp 0", ack_token, msg_token, msg_doc); end
      checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got %b exp 1", req_ready); end
   endtask

   task automatic test_single();
      do_reset();
      req_valid = 1'b1; req_any = 1'b0; req_doc = 2'd2;
      tick();
      req_valid = 1'b0;
      checks++; if (ack_valid !== 1'b1 || ack_token !== 8'd0) begin failures++; $display("FAIL single_ack got v=%b tok=%0d exp 1 0", ack_valid, ack_token); end
      checks++; if (msg_valid !== 1'b0) begin failures++; $display("FAIL single_no_early_msg got %b exp 0", msg_valid); end
      tick();
      checks++; if (msg_valid !== 1'b1 || msg_doc !== 2'd2 || msg_token !== 8'd0) begin failures++; $display("FAIL single_msg got v=%b doc=%0d tok=%0d exp 1 2 0", msg_valid, msg_doc, msg_token); end
      checks++; if (ack_valid !== 1'b0) begin failures++; $display("FAIL single_ack_pulse got %b exp 0", ack_valid); end
      checks++; if (doc_busy !== 4'b0100) begin failures++; $display("FAIL single_busy_start got %b exp 0100", doc_busy); end
      for (int c = 0; c < 9; c++) begin
         tick();
         checks++; if (doc_busy !== 4'b0100 || msg_valid !== 1'b0) begin failures++; $display("FAIL single_busy_hold cyc=%0d got busy=%b msg=%b exp 0100 0", c, doc_busy, msg_valid); end
      end
      tick();
      checks++; if (doc_busy !== 4'b0000) begin failures++; $display("FAIL single_busy_clear got %b exp 0000", doc_busy); end
   endtask

   task automatic test_back_to_back();
      do_reset();
      for (int i = 0; i < 5; i++) begin
         req_valid = 1'b1; req_any = 1'b1; req_doc = 2'd3;
         tick();
         checks++; if (ack_valid !== 1'b1 || ack_token !== 8'(i)) begin failures++; $display("FAIL b2b_ack i=%0d got v=%b tok=%0d exp 1 %0d", i, ack_valid, ack_token, i); end
         if (i >= 1) begin
            checks++; if (msg_valid !== 1'b1 || msg_doc !== 2'(i - 1) || msg_token !== 8'(i - 1)) begin failures++; $display("FAIL b2b_msg i=%0d got v=%b doc=%0d tok=%0d exp 1 %0d %0d", i, msg_valid, msg_doc, msg_token, i - 1, i - 1); end
         end
      end
      req_valid = 1'b0;
      checks++; if (q_count !== 4'd1 || doc_busy !== 4'b1111) begin failures++; $display("FAIL b2b_state got q=%0d busy=%b exp 1 1111", q_count, doc_busy); end
      for (int c = 0; c < 7; c++) begin
         tick();
         checks++; if (msg_valid !== 1'b0) begin failures++; $display("FAIL b2b_wait cyc=%0d got %b exp 0", c, msg_valid); end
      end
      tick();
      checks++; if (msg_valid !== 1'b1 || msg_doc !== 2'd0 || msg_token !== 8'd4) begin failures++; $display("FAIL b2b_tok4 got v=%b doc=%0d tok=%0d exp 1 0 4", msg_valid, msg_doc, msg_token); end
      checks++; if (q_count !== 4'd0) begin failures++; $display("FAIL b2b_empty got %0d exp 0", q_count); end
   endtask

   task automatic test_hol();
      do_reset();
      req_valid = 1'b1; req_any = 1'b0; req_doc = 2'd1;
      tick();
      req_valid = 1'b0;
      tick();
      checks++; if (doc_busy !== 4'b0010) begin failures++; $display("FAIL hol_setup got %b exp 0010", doc_busy); end
      req_valid = 1'b1; req_any = 1'b0; req_doc = 2'd1;
      tick();
      req_any = 1'b1; req_doc = 2'd0;
      tick();
      req_valid = 1'b0;
      for (int c = 0; c < 3; c++) begin
         checks++; if (msg_valid !== 1'b0 || q_count !== 4'd2) begin failures++; $display("FAIL hol_blocked cyc=%0d got msg=%b q=%0d exp 0 2", c, msg_valid, q_count); end
         tick();
      end
      doc_release = 4'b0010;
      tick();
      doc_release = 4'b0000;
      checks++; if (msg_valid !== 1'b0 || doc_busy !== 4'b0000) begin failures++; $display("FAIL hol_release got msg=%b busy=%b exp 0 0000", msg_valid, doc_busy); end
      tick();
      checks++; if (msg_valid !== 1'b1 || msg_doc !== 2'd1 || msg_token !== 8'd1) begin failures++; $display("FAIL hol_head got v=%b doc=%0d tok=%0d exp 1 1 1", msg_valid, msg_doc, msg_token); end
      tick();
      checks++; if (msg_valid !== 1'b1 || msg_doc !== 2'd0 || msg_token !== 8'd2) begin failures++; $display("FAIL hol_any got v=%b doc=%0d tok=%0d exp 1 0 2", msg_valid, msg_doc, msg_token); end
      checks++; if (doc_busy !== 4'b0011) begin failures++; $display("FAIL hol_busy got %b exp 0011", doc_busy); end
   endtask

   task automatic test_full();
      do_reset();
      req_valid = 1'b1; req_any = 1'b0; req_doc = 2'd0;
      for (int e = 1; e <= 9; e++) tick();
      checks++; if (q_count !== 4'd8 || req_ready !== 1'b0) begin failures++; $display("FAIL full_state got q=%0d ready=%b exp 8 0", q_count, req_ready); end
      for (int c = 0; c < 3; c++) begin
         tick();
         checks++; if (ack_valid !== 1'b0 || q_count !== 4'd8 || req_ready !== 1'b0) begin failures++; $display("FAIL full_reject cyc=%0d got ack=%b q=%0d ready=%b exp 0 8 0", c, ack_valid, q_count, req_ready); end
      end
      tick();
      req_valid = 1'b0;
      checks++; if (ack_valid !== 1'b0 || msg_valid !== 1'b1 || msg_token !== 8'd1) begin failures++; $display("FAIL full_pop got ack=%b msg=%b tok=%0d exp 0 1 1", ack_valid, msg_valid, msg_token); end
      checks++; if (q_count !== 4'd7 || req_ready !== 1'b1) begin failures++; $display("FAIL full_slot got q=%0d ready=%b exp 7 1", q_count, req_ready); end
   endtask

   task automatic test_token_wrap();
      do_reset();
      for (int i = 0; i < 9; i++) begin
         req_valid = 1'b1; req_any = 1'b1; req_doc = 2'd0;
         tick();
         checks++; if (w_ack_valid !== 1'b1 || w_ack_token !== 3'(i % 8)) begin failures++; $display("FAIL wrap_ack i=%0d got v=%b tok=%0d exp 1 %0d", i, w_ack_valid, w_ack_token, i % 8); end
      end
      req_valid = 1'b0;
   endtask

   task automatic test_reset_mid();
      do_reset();
      req_valid = 1'b1; req_any = 1'b0;
      req_doc = 2'd0; tick();
      req_doc = 2'd1; tick();
      req_doc = 2'd0; tick(); tick(); tick();
      req_valid = 1'b0;
      checks++; if (q_count !== 4'd3 || doc_busy !== 4'b0011) begin failures++; $display("FAIL mid_setup got q=%0d busy=%b exp 3 0011", q_count, doc_busy); end
      rst = 1'b1;
      tick();
      checks++; if (q_count !== 4'd0 || doc_busy !== 4'b0000 || msg_valid !== 1'b0 || req_ready !== 1'b0) begin failures++; $display("FAIL mid_reset got q=%0d busy=%b msg=%b ready=%b exp 0 0000 0 0", q_count, doc_busy, msg_valid, req_ready); end
      rst = 1'b0;
      for (int c = 0; c < 3; c++) begin
         tick();
         checks++; if (msg_valid !== 1'b0) begin failures++; $display("FAIL mid_no_msg cyc=%0d got %b exp 0", c, msg_valid); end
      end
      req_valid = 1'b1; req_any = 1'b1;
      tick();
      req_valid = 1'b0;
      checks++; if (ack_valid !== 1'b1 || ack_token !== 8'd0) begin failures++; $display("FAIL mid_token got v=%b tok=%0d exp 1 0", ack_valid, ack_token); end
   endtask

   initial begin
      rst = 1'b1; req_valid = 1'b0; req_any = 1'b0; req_doc = '0; doc_release = '0;
      test_reset();
      test_single();
      test_back_to_back();
      test_hol();
      test_full();
      test_token_wrap();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
